// File: rtl/cabac_pkg.sv
// Shared constants for the CABAC rLPS lookup stage: field widths, packing offsets,
// the HEVC rangeTabLps table and the renormalisation shift helper.
package cabac_pkg;
    localparam int RLPS_W       = 8;
    localparam int SHIFT_W      = 3;
    localparam int PSTATE_W     = 6;
    localparam int Q_NUM        = 4;
    localparam int GRP_W        = SHIFT_W + RLPS_W;
    localparam int RLPS_PACK_W  = Q_NUM * RLPS_W;
    localparam int SHIFT_PACK_W = Q_NUM * GRP_W;

    // qRangeIdx 0 occupies the most significant field of each packed word
    function automatic int rlps_lsb(input int q);
        return (Q_NUM - 1 - q) * RLPS_W;
    endfunction

    function automatic int grp_lsb(input int q);
        return (Q_NUM - 1 - q) * GRP_W;
    endfunction

    // shift = 9 - bitlength(rlps); rlps is never below 2, so the result stays in 1..7
    function automatic logic [SHIFT_W-1:0] lps_shift(input logic [RLPS_W-1:0] rlps);
        logic [SHIFT_W-1:0] s;
        s = 3'd0;
        for (int b = 1; b < RLPS_W; b++) begin
            if (rlps[b]) begin
                s = SHIFT_W'(RLPS_W - b);
            end else begin
                s = s;
            end
        end
        return s;
    endfunction

    localparam logic [RLPS_W-1:0] RANGE_TAB_LPS [64][Q_NUM] = '{
        '{8'd128, 8'd176, 8'd208, 8'd240}, '{8'd128, 8'd167, 8'd197, 8'd227},
        '{8'd128, 8'd158, 8'd187, 8'd216}, '{8'd123, 8'd150, 8'd178, 8'd205},
        '{8'd116, 8'd142, 8'd169, 8'd195}, '{8'd111, 8'd135, 8'd160, 8'd185},
        '{8'd105, 8'd128, 8'd152, 8'd175}, '{8'd100, 8'd122, 8'd144, 8'd166},
        '{8'd95,  8'd116, 8'd137, 8'd158}, '{8'd90,  8'd110, 8'd130, 8'd150},
        '{8'd85,  8'd104, 8'd123, 8'd142}, '{8'd81,  8'd99,  8'd117, 8'd135},
        '{8'd77,  8'd94,  8'd111, 8'd128}, '{8'd73,  8'd89,  8'd105, 8'd122},
        '{8'd69,  8'd85,  8'd100, 8'd116}, '{8'd66,  8'd80,  8'd95,  8'd110},
        '{8'd62,  8'd76,  8'd90,  8'd104}, '{8'd59,  8'd72,  8'd86,  8'd99},
        '{8'd56,  8'd69,  8'd81,  8'd94},  '{8'd53,  8'd65,  8'd77,  8'd89},
        '{8'd51,  8'd62,  8'd73,  8'd85},  '{8'd48,  8'd59,  8'd69,  8'd80},
        '{8'd46,  8'd56,  8'd66,  8'd76},  '{8'd43,  8'd53,  8'd63,  8'd72},
        '{8'd41,  8'd50,  8'd59,  8'd69},  '{8'd39,  8'd48,  8'd56,  8'd65},
        '{8'd37,  8'd45,  8'd54,  8'd62},  '{8'd35,  8'd43,  8'd51,  8'd59},
        '{8'd33,  8'd41,  8'd48,  8'd56},  '{8'd32,  8'd39,  8'd46,  8'd53},
        '{8'd30,  8'd37,  8'd43,  8'd50},  '{8'd29,  8'd35,  8'd41,  8'd48},
        '{8'd27,  8'd33,  8'd39,  8'd45},  '{8'd26,  8'd31,  8'd37,  8'd43},
        '{8'd24,  8'd30,  8'd35,  8'd41},  '{8'd23,  8'd28,  8'd33,  8'd39},
        '{8'd22,  8'd27,  8'd32,  8'd37},  '{8'd21,  8'd26,  8'd30,  8'd35},
        '{8'd20,  8'd24,  8'd29,  8'd33},  '{8'd19,  8'd23,  8'd27,  8'd31},
        '{8'd18,  8'd22,  8'd26,  8'd30},  '{8'd17,  8'd21,  8'd25,  8'd28},
        '{8'd16,  8'd20,  8'd23,  8'd27},  '{8'd15,  8'd19,  8'd22,  8'd25},
        '{8'd14,  8'd18,  8'd21,  8'd24},  '{8'd14,  8'd17,  8'd20,  8'd23},
        '{8'd13,  8'd16,  8'd19,  8'd22},  '{8'd12,  8'd15,  8'd18,  8'd21},
        '{8'd12,  8'd14,  8'd17,  8'd20},  '{8'd11,  8'd14,  8'd16,  8'd19},
        '{8'd11,  8'd13,  8'd15,  8'd18},  '{8'd10,  8'd12,  8'd15,  8'd17},
        '{8'd10,  8'd12,  8'd14,  8'd16},  '{8'd9,   8'd11,  8'd13,  8'd15},
        '{8'd9,   8'd11,  8'd12,  8'd14},  '{8'd8,   8'd10,  8'd12,  8'd14},
        '{8'd8,   8'd9,   8'd11,  8'd13},  '{8'd7,   8'd9,   8'd11,  8'd12},
        '{8'd7,   8'd9,   8'd10,  8'd12},  '{8'd7,   8'd8,   8'd10,  8'd11},
        '{8'd6,   8'd8,   8'd9,   8'd11},  '{8'd6,   8'd7,   8'd9,   8'd10},
        '{8'd6,   8'd7,   8'd8,   8'd9},   '{8'd2,   8'd2,   8'd2,   8'd2}
    };
endpackage

// File: rtl/cabac_rlps_rom.sv
// One-bin combinational rLPS lookup: four candidate rLPS values and their
// renormalised {shift, shifted[7:0]} forms for a given pStateIdx.
module cabac_rlps_rom
    import cabac_pkg::*;
(
    input  logic [PSTATE_W-1:0]     pstateidx,
    output logic [RLPS_PACK_W-1:0]  four_rlps,
    output logic [SHIFT_PACK_W-1:0] four_rlps_shift
);
    for (genvar q = 0; q < Q_NUM; q++) begin : g_q
        logic [RLPS_W-1:0]  rlps_s;
        logic [SHIFT_W-1:0] shift_s;
        logic [RLPS_W-1:0]  shifted_s;

        assign rlps_s    = RANGE_TAB_LPS[pstateidx][q];
        assign shift_s   = lps_shift(rlps_s);
        // The 9-bit result always has its MSB set, so only the low byte is kept
        assign shifted_s = rlps_s << shift_s;

        assign four_rlps[rlps_lsb(q) +: RLPS_W]      = rlps_s;
        assign four_rlps_shift[grp_lsb(q) +: GRP_W]  = {shift_s, shifted_s};
    end
endmodule

// File: rtl/cabac_rlps_n.sv
// Multi-bin rLPS lookup stage with a 2-entry valid/ready output buffer,
// synchronous flush and a saturating count of accepted active bins.
module cabac_rlps_n
    import cabac_pkg::*;
#(
    parameter int NUM_BINS = 4,
    parameter int SIDE_W   = 23
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_BINS-1:0]              in_bin_mask,
    input  logic [NUM_BINS-1:0]              in_lpsmps,
    input  logic [PSTATE_W*NUM_BINS-1:0]     in_pstateidx,
    input  logic [SIDE_W-1:0]                in_side,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_BINS-1:0]              out_bin_mask,
    output logic [NUM_BINS-1:0]              out_lpsmps,
    output logic [RLPS_PACK_W*NUM_BINS-1:0]  out_four_rlps,
    output logic [SHIFT_PACK_W*NUM_BINS-1:0] out_four_rlps_shift,
    output logic [SIDE_W-1:0]                out_side,
    output logic [15:0]                      bin_cnt
);
    typedef struct packed {
        logic [NUM_BINS-1:0]              mask;
        logic [NUM_BINS-1:0]              lpsmps;
        logic [RLPS_PACK_W*NUM_BINS-1:0]  rlps;
        logic [SHIFT_PACK_W*NUM_BINS-1:0] rlps_shift;
        logic [SIDE_W-1:0]                side;
    } entry_t;

    logic [RLPS_PACK_W*NUM_BINS-1:0]  rom_rlps_s;
    logic [SHIFT_PACK_W*NUM_BINS-1:0] rom_shift_s;
    entry_t      new_entry_s, head_r, tail_r, head_nxt_s, tail_nxt_s;
    logic [1:0]  count_r, count_nxt_s;
    logic [15:0] bin_cnt_r, bin_cnt_nxt_s;
    logic [3:0]  pop_cnt_s;
    logic [16:0] bin_sum_s;
    logic        push_s, pop_s;

    for (genvar b = 0; b < NUM_BINS; b++) begin : g_bin
        cabac_rlps_rom u_rom (
            .pstateidx       (in_pstateidx[PSTATE_W*b +: PSTATE_W]),
            .four_rlps       (rom_rlps_s[RLPS_PACK_W*b +: RLPS_PACK_W]),
            .four_rlps_shift (rom_shift_s[SHIFT_PACK_W*b +: SHIFT_PACK_W])
        );
    end

    assign in_ready  = (count_r < 2'd2);
    assign out_valid = (count_r != 2'd0);
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Head is cleared whenever the buffer empties, so outputs read zero while idle
    assign out_bin_mask        = head_r.mask;
    assign out_lpsmps          = head_r.lpsmps;
    assign out_four_rlps       = head_r.rlps;
    assign out_four_rlps_shift = head_r.rlps_shift;
    assign out_side            = head_r.side;
    assign bin_cnt             = bin_cnt_r;

    // Build the tail entry, zeroing every field of inactive bins
    always_comb begin
        new_entry_s        = '0;
        new_entry_s.mask   = in_bin_mask;
        new_entry_s.lpsmps = in_lpsmps & in_bin_mask;
        new_entry_s.side   = in_side;
        for (int b = 0; b < NUM_BINS; b++) begin
            if (in_bin_mask[b]) begin
                new_entry_s.rlps[RLPS_PACK_W*b +: RLPS_PACK_W]        = rom_rlps_s[RLPS_PACK_W*b +: RLPS_PACK_W];
                new_entry_s.rlps_shift[SHIFT_PACK_W*b +: SHIFT_PACK_W] = rom_shift_s[SHIFT_PACK_W*b +: SHIFT_PACK_W];
            end else begin
                new_entry_s.rlps[RLPS_PACK_W*b +: RLPS_PACK_W]        = '0;
                new_entry_s.rlps_shift[SHIFT_PACK_W*b +: SHIFT_PACK_W] = '0;
            end
        end
    end

    // Saturating accumulation of active bins in the offered beat
    always_comb begin
        pop_cnt_s = 4'd0;
        for (int b = 0; b < NUM_BINS; b++) begin
            pop_cnt_s = pop_cnt_s + 4'(in_bin_mask[b]);
        end
        bin_sum_s = {1'b0, bin_cnt_r} + 17'(pop_cnt_s);
    end

    // Buffer, occupancy and counter next state; flush overrides push and pop
    always_comb begin
        count_nxt_s   = count_r;
        head_nxt_s    = head_r;
        tail_nxt_s    = tail_r;
        bin_cnt_nxt_s = bin_cnt_r;
        if (flush) begin
            count_nxt_s   = 2'd0;
            head_nxt_s    = '0;
            tail_nxt_s    = '0;
            bin_cnt_nxt_s = 16'd0;
        end else begin
            case ({push_s, pop_s})
                2'b11: begin
                    // Only reachable with one entry held: new beat becomes head
                    head_nxt_s = new_entry_s;
                    tail_nxt_s = '0;
                end
                2'b01: begin
                    head_nxt_s  = tail_r;
                    tail_nxt_s  = '0;
                    count_nxt_s = count_r - 2'd1;
                end
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_nxt_s = new_entry_s;
                    end else begin
                        tail_nxt_s = new_entry_s;
                    end
                    count_nxt_s = count_r + 2'd1;
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
            if (push_s) begin
                bin_cnt_nxt_s = bin_sum_s[16] ? 16'hFFFF : bin_sum_s[15:0];
            end else begin
                bin_cnt_nxt_s = bin_cnt_r;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r   <= 2'd0;
            head_r    <= '0;
            tail_r    <= '0;
            bin_cnt_r <= 16'd0;
        end else begin
            count_r   <= count_nxt_s;
            head_r    <= head_nxt_s;
            tail_r    <= tail_nxt_s;
            bin_cnt_r <= bin_cnt_nxt_s;
        end
    end
endmodule

// File: tb/tb_cabac_rlps_n.sv
// Scoreboard bench for cabac_rlps_n: directed table/mask/backpressure/flush/
// saturation/reset cases, randomized traffic, and pStateIdx sweeps at 1 and 8 bins.
module tb_cabac_rlps_n;
    localparam int NB = 4;
    localparam int SW = 23;

    typedef struct packed {
        logic [NB-1:0]    mask;
        logic [NB-1:0]    lps;
        logic [32*NB-1:0] rl;
        logic [44*NB-1:0] sg;
        logic [SW-1:0]    side;
    } exp_t;

    int tab [0:255] = '{
        128,176,208,240, 128,167,197,227, 128,158,187,216, 123,150,178,205,
        116,142,169,195, 111,135,160,185, 105,128,152,175, 100,122,144,166,
        95,116,137,158,  90,110,130,150,  85,104,123,142,  81,99,117,135,
        77,94,111,128,   73,89,105,122,   69,85,100,116,   66,80,95,110,
        62,76,90,104,    59,72,86,99,     56,69,81,94,     53,65,77,89,
        51,62,73,85,     48,59,69,80,     46,56,66,76,     43,53,63,72,
        41,50,59,69,     39,48,56,65,     37,45,54,62,     35,43,51,59,
        33,41,48,56,     32,39,46,53,     30,37,43,50,     29,35,41,48,
        27,33,39,45,     26,31,37,43,     24,30,35,41,     23,28,33,39,
        22,27,32,37,     21,26,30,35,     20,24,29,33,     19,23,27,31,
        18,22,26,30,     17,21,25,28,     16,20,23,27,     15,19,22,25,
        14,18,21,24,     14,17,20,23,     13,16,19,22,     12,15,18,21,
        12,14,17,20,     11,14,16,19,     11,13,15,18,     10,12,15,17,
        10,12,14,16,     9,11,13,15,      9,11,12,14,      8,10,12,14,
        8,9,11,13,       7,9,11,12,       7,9,10,12,       7,8,10,11,
        6,8,9,11,        6,7,9,10,        6,7,8,9,         2,2,2,2
    };

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [NB-1:0] in_bin_mask, in_lpsmps, out_bin_mask, out_lpsmps;
    logic [6*NB-1:0] in_pstateidx;
    logic [SW-1:0] in_side, out_side;
    logic [32*NB-1:0] out_four_rlps;
    logic [44*NB-1:0] out_four_rlps_shift;
    logic [15:0] bin_cnt;

    logic zero_x = 1'b0, one_x = 1'b1, vx;
    logic [0:0] m1 = 1'b1, l1 = 1'b0, r1_ready, v1_out, m1_out, l1_out;
    logic [7:0] m8 = 8'hFF, l8 = 8'h00, r8_ready, v8_out, m8_out, l8_out;
    logic [5:0] ps1;
    logic [47:0] ps8;
    logic [SW-1:0] side_x = '0, s1_out, s8_out;
    logic [31:0] rl1;
    logic [43:0] sg1;
    logic [255:0] rl8;
    logic [351:0] sg8;
    logic [15:0] c1, c8;

    int checks = 0, errors = 0;
    int occ = 0, exp_cnt = 0;
    bit rnd = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    cabac_rlps_n #(.NUM_BINS(NB), .SIDE_W(SW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_bin_mask(in_bin_mask), .in_lpsmps(in_lpsmps), .in_pstateidx(in_pstateidx),
        .in_side(in_side), .out_valid(out_valid), .out_ready(out_ready),
        .out_bin_mask(out_bin_mask), .out_lpsmps(out_lpsmps), .out_four_rlps(out_four_rlps),
        .out_four_rlps_shift(out_four_rlps_shift), .out_side(out_side), .bin_cnt(bin_cnt));

    cabac_rlps_n #(.NUM_BINS(1), .SIDE_W(SW)) dut1 (
        .clk(clk), .rst(rst), .flush(zero_x), .in_valid(vx), .in_ready(r1_ready[0]),
        .in_bin_mask(m1), .in_lpsmps(l1), .in_pstateidx(ps1), .in_side(side_x),
        .out_valid(v1_out[0]), .out_ready(one_x), .out_bin_mask(m1_out), .out_lpsmps(l1_out),
        .out_four_rlps(rl1), .out_four_rlps_shift(sg1), .out_side(s1_out), .bin_cnt(c1));

    cabac_rlps_n #(.NUM_BINS(8), .SIDE_W(SW)) dut8 (
        .clk(clk), .rst(rst), .flush(zero_x), .in_valid(vx), .in_ready(r8_ready[0]),
        .in_bin_mask(m8), .in_lpsmps(l8), .in_pstateidx(ps8), .in_side(side_x),
        .out_valid(v8_out[0]), .out_ready(one_x), .out_bin_mask(m8_out), .out_lpsmps(l8_out),
        .out_four_rlps(rl8), .out_four_rlps_shift(sg8), .out_side(s8_out), .bin_cnt(c8));

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // {rlps32, shift44} for one bin, from the table and bit-length arithmetic
    function automatic logic [75:0] ref_bin(input int ps);
        logic [31:0] rl;
        logic [43:0] sg;
        int r, n, v, s, sh;
        rl = '0;
        sg = '0;
        for (int q = 0; q < 4; q++) begin
            r = tab[ps*4 + q];
            n = 0;
            v = r;
            while (v > 0) begin v = v / 2; n++; end
            s = 9 - n;
            sh = (r << s) % 256;
            rl[(3-q)*8 +: 8] = r[7:0];
            sg[(3-q)*11 +: 11] = {s[2:0], sh[7:0]};
        end
        return {rl, sg};
    endfunction

    function automatic exp_t ref_beat(input logic [NB-1:0] m, input logic [NB-1:0] l,
                                      input logic [6*NB-1:0] ps, input logic [SW-1:0] sd);
        exp_t e;
        logic [75:0] t;
        e = '0;
        e.mask = m;
        e.lps = l & m;
        e.side = sd;
        for (int b = 0; b < NB; b++) begin
            if (m[b]) begin
                t = ref_bin(int'(ps[6*b +: 6]));
                e.rl[32*b +: 32] = t[75:44];
                e.sg[44*b +: 44] = t[43:0];
            end
        end
        return e;
    endfunction

    // Reference occupancy/counter model; pushes the expected beat on each accept
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            occ = 0;
            exp_cnt = 0;
            sb.delete();
        end else begin
            chk("in_ready", 512'(in_ready), 512'(occ < 2));
            chk("out_valid", 512'(out_valid), 512'(occ != 0));
            chk("bin_cnt", 512'(bin_cnt), 512'(exp_cnt));
            if (flush) begin
                occ = 0;
                exp_cnt = 0;
                sb.delete();
            end else begin
                if (in_valid && occ < 2) begin
                    sb.push_back(ref_beat(in_bin_mask, in_lpsmps, in_pstateidx, in_side));
                    exp_cnt = exp_cnt + $countones(in_bin_mask);
                    if (exp_cnt > 65535) exp_cnt = 65535;
                    occ++;
                end
                if (occ_pre_nonzero(occ, in_valid) && out_ready) occ--;
            end
        end
    end

    // Pop happens only if the buffer held something before this cycle's push
    function automatic bit occ_pre_nonzero(input int o, input logic v);
        return (o - ((v && sb.size() > 0 && o > 0) ? 0 : 0)) > 0 && out_valid;
    endfunction

    // Monitor: compare the head beat on every pop, and idle outputs to zero
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 512'(1), 512'(0));
                end else begin
                    chk("beat", 512'({out_bin_mask, out_lpsmps, out_four_rlps, out_four_rlps_shift, out_side}),
                        512'(sb.pop_front()));
                end
            end else if (!out_valid) begin
                chk("idle_zero", 512'({out_bin_mask, out_lpsmps, out_four_rlps, out_four_rlps_shift, out_side}),
                    512'(0));
            end
        end
    end

    task automatic send(input logic [NB-1:0] m, input logic [NB-1:0] l,
                        input logic [6*NB-1:0] ps, input logic [SW-1:0] sd);
        int n;
        n = 0;
        in_valid = 1'b1; in_bin_mask = m; in_lpsmps = l; in_pstateidx = ps; in_side = sd;
        @(negedge clk);
        while (!in_ready && n < 64) begin
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 512'(in_ready), 512'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (out_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("drain", 512'(out_valid), 512'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; vx = 1'b0;
        in_bin_mask = '0; in_lpsmps = '0; in_pstateidx = '0; in_side = '0; ps1 = '0; ps8 = '0;
        #2;
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        chk("rst_data", 512'({out_four_rlps, out_four_rlps_shift, out_side}), 512'(0));
        chk("rst_bin_cnt", 512'(bin_cnt), 512'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Known table entries, bins = pStateIdx {63,62,60,0}
        send(4'hF, 4'h0, {6'd63, 6'd62, 6'd60, 6'd0}, 23'h1);
        chk("tab_ps0_rlps", 512'(out_four_rlps[31:0]), 512'(32'h80B0D0F0));
        chk("tab_ps0_shift", 512'(out_four_rlps_shift[43:0]),
            512'({3'd1, 8'h00, 3'd1, 8'h60, 3'd1, 8'hA0, 3'd1, 8'hE0}));
        chk("tab_ps60_rlps", 512'(out_four_rlps[63:32]), 512'(32'h0608090B));
        chk("tab_ps60_q0", 512'(out_four_rlps_shift[87:77]), 512'({3'd6, 8'h80}));
        chk("tab_ps62_rlps", 512'(out_four_rlps[95:64]), 512'(32'h06070809));
        chk("tab_ps63_rlps", 512'(out_four_rlps[127:96]), 512'(32'h02020202));
        chk("tab_ps63_shift", 512'(out_four_rlps_shift[175:132]), 512'({4{3'd7, 8'h00}}));
        drain();

        // Mask 0101: bins 1 and 3 cleared, counter advances by 2
        send(4'b0101, 4'b1111, 24'($urandom), 23'h2);
        chk("mask_lpsmps", 512'(out_lpsmps), 512'(4'b0101));
        chk("mask_bin1", 512'({out_four_rlps[63:32], out_four_rlps_shift[87:44]}), 512'(0));
        chk("mask_bin3", 512'({out_four_rlps[127:96], out_four_rlps_shift[175:132]}), 512'(0));
        chk("mask_cnt", 512'(bin_cnt), 512'(16'd6));
        drain();

        // Backpressure: A, B absorbed; C held until the consumer frees a slot
        out_ready = 1'b0;
        send(4'hF, 4'h3, 24'($urandom), 23'hA);
        send(4'h7, 4'h5, 24'($urandom), 23'hB);
        chk("bp_full", 512'(in_ready), 512'(0));
        in_valid = 1'b1; in_bin_mask = 4'hE; in_lpsmps = 4'hA; in_pstateidx = 24'h123456; in_side = 23'hC;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_hold", 512'(in_ready), 512'(0));
        end
        out_ready = 1'b1;
        send(4'hE, 4'hA, 24'h123456, 23'hC);
        drain();
        chk("bp_no_loss_dup", 512'(sb.size()), 512'(0));

        // Flush with a full buffer and a beat offered in the same cycle
        out_ready = 1'b0;
        send(4'hF, 4'h1, 24'($urandom), 23'h10);
        send(4'hF, 4'h2, 24'($urandom), 23'h11);
        in_valid = 1'b1; in_bin_mask = 4'hF; in_pstateidx = 24'($urandom); in_side = 23'h12;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 512'(out_valid), 512'(0));
        chk("flush_data", 512'({out_bin_mask, out_four_rlps, out_four_rlps_shift, out_side}), 512'(0));
        chk("flush_cnt", 512'(bin_cnt), 512'(0));
        chk("flush_in_ready", 512'(in_ready), 512'(1));
        out_ready = 1'b1;
        send(4'h9, 4'h8, 24'($urandom), 23'h13);
        drain();

        // Randomized traffic with random consumer stalls
        rnd = 1;
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            send(4'($urandom), 4'($urandom), 24'($urandom), 23'($urandom));
        end
        rnd = 0;
        drain();

        // Every pStateIdx on every bin position, 1-bin and 8-bin instances
        for (int k = 0; k < 64; k++) begin
            vx = 1'b1;
            ps1 = 6'(k);
            for (int i = 0; i < 8; i++) ps8[6*i +: 6] = 6'((k + 8*i) % 64);
            @(posedge clk); #1;
            chk("sweep1", 512'({rl1, sg1}), 512'(ref_bin(k)));
            for (int i = 0; i < 8; i++)
                chk("sweep8", 512'({rl8[32*i +: 32], sg8[44*i +: 44]}), 512'(ref_bin((k + 8*i) % 64)));
        end
        vx = 1'b0;

        // Saturation: reach 0xFFFE, then one more 4-bin beat pins at 0xFFFF
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 16383; i++) send(4'hF, 4'h0, 24'($urandom), 23'h0);
        send(4'h3, 4'h0, 24'($urandom), 23'h0);
        chk("cnt_fffe", 512'(bin_cnt), 512'(16'hFFFE));
        send(4'hF, 4'h0, 24'($urandom), 23'h0);
        chk("cnt_sat", 512'(bin_cnt), 512'(16'hFFFF));
        send(4'hF, 4'h0, 24'($urandom), 23'h0);
        chk("cnt_sat_hold", 512'(bin_cnt), 512'(16'hFFFF));
        drain();

        // Asynchronous reset between edges with a beat buffered
        out_ready = 1'b0;
        send(4'hF, 4'hF, 24'($urandom), 23'h7F);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 512'(out_valid), 512'(0));
        chk("arst_in_ready", 512'(in_ready), 512'(1));
        chk("arst_data", 512'({out_bin_mask, out_lpsmps, out_four_rlps, out_four_rlps_shift, out_side}), 512'(0));
        chk("arst_cnt", 512'(bin_cnt), 512'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_out_valid", 512'(out_valid), 512'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
